// File: rtl/switch_input.sv
// switch_input: memory-mapped input for the board's active-low slide switches
// and push buttons. Each pin goes through a 2-flop synchroniser and a
// tick-sampled debouncer. The CPU bridge reads the result as a clean
// active-high value.
// Build option SWITCH_INPUT_IRQ_EN adds per-bit change flags (W1C), an
// interrupt mask and a level interrupt. Without it, FLAG and MASK read 0
// and irq is tied low.
module switch_input #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       Addr,
  input  logic [31:0]      Din,
  input  logic             We,
  output logic [31:0]      Dout,
  output logic             irq
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] sync1, sync2, s;
  logic [WIDTH-1:0] hist [STABLE_N];
  logic [WIDTH-1:0] all_one, all_zero;
  logic [WIDTH-1:0] deb, deb_next;
  logic             unused_bits;

  // Upper Din bits (and Din/We entirely without the IRQ option) have no effect.
  assign unused_bits = ^{Din, We};

  // Two-flop synchroniser; resets to all-ones, i.e. every switch released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Prescaler that produces a one-cycle sample tick every TICK_DIV clocks.
  always_ff @(posedge clk) begin
    if (!rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + CW'(1);
  end

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  // Sample history: hist[0] is the newest tick sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STABLE_N; k++) hist[k] <= '0;
    end else if (tick) begin
      hist[0] <= s;
      for (int k = 1; k < STABLE_N; k++) hist[k] <= hist[k-1];
    end
  end

  // Unanimous check over the history as it will look after this tick's shift.
  always_comb begin
    all_one  = s;
    all_zero = ~s;
    for (int k = 0; k < STABLE_N - 1; k++) begin
      all_one  = all_one & hist[k];
      all_zero = all_zero & ~hist[k];
    end
    deb_next = deb;
    if (tick) deb_next = (deb | all_one) & ~all_zero;
  end

  // Debounced level register.
  always_ff @(posedge clk) begin
    if (!rst) deb <= '0;
    else deb <= deb_next;
  end

`ifdef SWITCH_INPUT_IRQ_EN
  logic [WIDTH-1:0] flag, mask, w1c;

  assign w1c = (We && Addr == 2'd1) ? Din[WIDTH-1:0] : '0;

  // Change flags (a new change beats a same-cycle clear), mask and registered irq.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      flag <= (flag & ~w1c) | (deb ^ deb_next);
      if (We && Addr == 2'd2) mask <= Din[WIDTH-1:0];
      irq <= |(flag & mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; bits above WIDTH always read 0.
  always_comb begin
    Dout = '0;
    case (Addr)
      2'd0: Dout[WIDTH-1:0] = deb;
`ifdef SWITCH_INPUT_IRQ_EN
      2'd1: Dout[WIDTH-1:0] = flag;
      2'd2: Dout[WIDTH-1:0] = mask;
`endif
      default: Dout = '0;
    endcase
  end

endmodule

// File: doc/switch_input.md
Name: switch_input

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the board LED output register.
- Samples the board's active-low slide switches / push buttons and synchronises and debounces them.
- Presents a clean active-high value to the CPU bridge.
- Optionally latches per-bit change flags and raises a level interrupt to CP0.

Parameters:
WIDTH, 16, number of switch inputs (1..32)
TICK_DIV, 50000, clk cycles per debounce sample tick (>=2)
STABLE_N, 3, consecutive equal tick samples required to accept a new level (2..8)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset)
sw_in  input  WIDTH  raw switch pins, active-low (0 = on), asynchronous to clk
Addr  input  2  register select (CPU byte address bits [3:2])
Din  input  32  write data from bridge
We  input  1  write enable, one-cycle strobe
Dout  output  32  read data, combinational from Addr
irq  output  1  interrupt request, level, active-high

Behaviour:
- Synchroniser: 2-flop chain per bit.
  - Reset value all-ones, i.e. all switches off.
  - Output `s = ~sync2` is active-high.
- Prescaler: `tick_cnt` counts 0..TICK_DIV-1 and wraps.
  - `tick` is asserted for the single cycle where `tick_cnt == TICK_DIV-1`.
  - Reset to 0.
- Per-bit history: STABLE_N-deep shift register, shifted on tick only, new sample = `s[i]`. Reset to 0.
- Debounced value `deb[i]` (reset 0):
  - Updated only on tick.
  - If every history entry after the shift equals `v` and `v != deb[i]`, then `deb[i] <= v` at that edge.
  - Otherwise `deb[i]` is held.
  - A glitch shorter than STABLE_N ticks never reaches `deb`.
- Latency, raw edge held stable to `deb` change:
  - Minimum 2 + (STABLE_N-1)*TICK_DIV + 1 cycles.
  - Maximum 2 + STABLE_N*TICK_DIV cycles.
- Register map (unused upper bits read 0):
  - Addr 0 DATA: read `deb`. Writes ignored.
  - Addr 1 FLAG: read `flag`. Write 1 clears that bit (W1C).
  - Addr 2 MASK: read/write `mask` (reset 0).
  - Addr 3: reads 0, writes ignored.
- `flag[i]` (reset 0) is set on the cycle `deb[i]` changes, either direction.
- Simultaneous W1C and set on the same bit: set wins, flag stays 1.
- `irq = |(flag & mask)`, registered. Rises the cycle after the flag/mask condition holds; reset 0.
- Writing MASK to 0 clears `irq` on the next cycle without clearing flags.
- `We` with any Addr never disturbs sync, prescaler, history or deb.
- Reset asserted mid-debounce: all state returns to reset values on that edge.
  - After release, `deb` follows the pins again after the normal latency.
  - No flag is generated by reset itself.
- WIDTH < 32: Din bits above WIDTH ignored, Dout bits above WIDTH are 0.

Optional Feature:
- Macro: `SWITCH_INPUT_IRQ_EN`.
- Defined: FLAG, MASK and `irq` exist as described above.
- Undefined:
  - No flag or mask storage.
  - Addr 1 and Addr 2 read 0 and writes are ignored.
  - `irq` is tied 0.
  - DATA path and debounce timing are identical to the defined build.

Test Plan (TICK_DIV=4, STABLE_N=3, WIDTH=16, macro defined unless stated):
- Reset held low 3 cycles, `sw_in=16'hFFFF`, then released → DATA reads 0, FLAG 0, `irq` 0; `sw_in=16'hFFFE` → `deb[0]` becomes 1 within 2+12 cycles and not before 2+9; DATA reads 16'h0001.
- Glitch: `sw_in[3]` driven 0 for 6 cycles then back to 1 → DATA stays 16'h0000, FLAG stays 0.
- MASK=16'h0001 written, bit 0 pressed → FLAG=16'h0001 and `irq`=1 one cycle after `deb` changes; write FLAG 16'h0001 → FLAG 0 and `irq` 0 next cycle; release → flag sets again.
- W1C of bit 0 on the exact cycle `deb[0]` toggles → FLAG bit 0 reads 1 afterwards.
- Reset pulsed while bit 5 is mid-debounce (2 ticks stable) → after release, DATA=0, FLAG=0, no `irq`; `deb[5]` rises only after a full fresh latency.
- Macro undefined: press bit 2, write 16'hFFFF to Addr 1 and Addr 2 → DATA=16'h0004; Addr 1/2 read 0; `irq` stays 0 throughout.
